// File: rtl/rs_16_14_decoder_core.sv
// RS(16,14) single-symbol-correcting decoder over GF(2^8).
// Collects a 128-bit block as four words, locates/corrects one symbol error, streams it back.
module rs_16_14_decoder_core #(
  parameter logic [8:0] PRIM_POLY  = 9'h11D,
  parameter bit         CORRECT_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i,
  output logic        done_o,
  output logic        cerr_o,
  output logic        ncerr_o,
  output logic [3:0]  err_pos_o
);

  function automatic logic [7:0] mul_a(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? PRIM_POLY[7:0] : 8'h00);
  endfunction

  // Entry k holds log_alpha(k); entry 0 is never consulted.
  function automatic logic [2047:0] gen_log_rom();
    logic [2047:0] rom;
    logic [7:0]    p;
    rom = '0;
    p   = 8'h01;
    for (int i = 0; i < 255; i++) begin
      rom[{p, 3'b000} +: 8] = 8'(i);
      p = mul_a(p);
    end
    return rom;
  endfunction

  localparam logic [2047:0] LOG_ROM = gen_log_rom();

  typedef enum logic [1:0] {StIdle, StCollect, StLocate, StOutput} state_e;

  state_e       state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic [1:0]   in_cnt_q, out_cnt_q;
  logic [127:0] blk_q;
  logic [7:0]   s0_q, s1_q;
  logic         cerr_q, ncerr_q;
  logic [3:0]   err_pos_q;

  logic         in_hs, out_hs;
  logic [7:0]   s0_base, s1_base, s0_upd, s1_upd;
  logic [7:0]   l0, l1, j;
  logic [8:0]   diff;
  logic         both_nz, loc_cerr, loc_ncerr;

  assign in_hs       = in_valid_i & in_ready_q;
  assign out_valid_o = (state_q == StOutput);
  assign out_hs      = out_valid_o & out_ready_i;

  // Horner step over one word: S1*a^4 ^ b3*a^3 ^ b2*a^2 ^ b1*a ^ b0.
  always_comb begin
    s0_base = (state_q == StIdle) ? 8'h00 : s0_q;
    s1_base = (state_q == StIdle) ? 8'h00 : s1_q;
    s0_upd  = s0_base ^ in_data_i[31:24] ^ in_data_i[23:16] ^ in_data_i[15:8] ^ in_data_i[7:0];
    s1_upd  = mul_a(mul_a(mul_a(mul_a(s1_base) ^ in_data_i[31:24]) ^ in_data_i[23:16])
                    ^ in_data_i[15:8]) ^ in_data_i[7:0];
  end

  always_comb begin
    l0        = LOG_ROM[{s0_q, 3'b000} +: 8];
    l1        = LOG_ROM[{s1_q, 3'b000} +: 8];
    diff      = {1'b0, l1} - {1'b0, l0};
    j         = diff[8] ? 8'(diff + 9'd255) : diff[7:0];
    both_nz   = (s0_q != 8'h00) && (s1_q != 8'h00);
    loc_cerr  = both_nz && (j < 8'd16);
    loc_ncerr = ((s0_q == 8'h00) != (s1_q == 8'h00)) || (both_nz && (j >= 8'd16));
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (in_hs) state_d = StCollect;
        StCollect: if (in_hs && in_cnt_q == 2'd3) state_d = StLocate;
        StLocate:  state_d = StOutput;
        StOutput:  if (out_hs && out_cnt_q == 2'd3) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
    in_ready_d = (state_d == StIdle) || (state_d == StCollect);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      in_cnt_q   <= 2'd0;
      out_cnt_q  <= 2'd0;
      blk_q      <= '0;
      s0_q       <= 8'h00;
      s1_q       <= 8'h00;
      cerr_q     <= 1'b0;
      ncerr_q    <= 1'b0;
      err_pos_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      if (clear_i) begin
        // Flags deliberately survive an abort.
        in_cnt_q  <= 2'd0;
        out_cnt_q <= 2'd0;
        blk_q     <= '0;
        s0_q      <= 8'h00;
        s1_q      <= 8'h00;
      end else begin
        unique case (state_q)
          StIdle, StCollect: begin
            if (in_hs) begin
              blk_q[{~in_cnt_q, 5'b00000} +: 32] <= in_data_i;
              s0_q     <= s0_upd;
              s1_q     <= s1_upd;
              in_cnt_q <= in_cnt_q + 2'd1;
            end
          end
          StLocate: begin
            cerr_q    <= loc_cerr;
            ncerr_q   <= loc_ncerr;
            err_pos_q <= loc_cerr ? j[3:0] : 4'd0;
            if (CORRECT_EN && loc_cerr) begin
              blk_q[{j[3:0], 3'b000} +: 8] <= blk_q[{j[3:0], 3'b000} +: 8] ^ s0_q;
            end
          end
          StOutput: begin
            if (out_hs) out_cnt_q <= out_cnt_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready_o = in_ready_q;
  assign out_data_o = out_valid_o ? blk_q[{~out_cnt_q, 5'b00000} +: 32] : 32'h0;
  assign done_o     = out_hs & (out_cnt_q == 2'd3) & ~clear_i;
  assign cerr_o     = cerr_q;
  assign ncerr_o    = ncerr_q;
  assign err_pos_o  = err_pos_q;

endmodule
